inst_fetch_responder: RTL and testbench
=======================================

Name: inst_fetch_responder

Overview:
- Memory-side responder for the instruction-fetch request/response handshake.
- Accepts a fetch request (request_i + instAddr_i) from the fetch unit and reads a 32-bit word from an internal instruction memory.
- Returns the word with a one-cycle dataOk_o pulse after a fixed latency.
- Sits between the way fetch units and the instruction store. It supports flush on jump and has a write port for program loading.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2^ADDR_W words.
- LATENCY, 2, cycles from request acceptance to the dataOk_o pulse; legal range 1..15.
- RESET_INST, 32'h0000_0013, value of inst_o while idle after reset (NOP).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- request_i  in  1  fetch request valid.
- instAddr_i  in  32  byte address of the fetch.
- flush_i  in  1  jump/flush; discards the in-flight request.
- ready_o  out  1  responder can accept a request this cycle.
- dataOk_o  out  1  one-cycle pulse; inst_o and err_o are valid.
- inst_o  out  32  fetched instruction.
- instAddr_o  out  32  address belonging to the current inst_o.
- err_o  out  1  misaligned fetch; valid with dataOk_o.
- wr_en_i  in  1  memory write enable (program load).
- wr_addr_i  in  ADDR_W  word address for the write.
- wr_data_i  in  32  write data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, ready_o=0 during the rst cycle, dataOk_o=0, inst_o=RESET_INST, instAddr_o=0, err_o=0, counter=0.
  - Memory contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - ready_o=1 unless flush_i=1.
  - On request_i && ready_o: latch instAddr_i, read mem[instAddr_i[ADDR_W+1:2]] into the data register, latch misalign = |instAddr_i[1:0].
  - counter=LATENCY-1. Next state is RESP if LATENCY==1, else WAIT.
- WAIT:
  - ready_o=0. The counter decrements each cycle; when it reaches 1, next state is RESP.
- RESP:
  - dataOk_o=1 for exactly this cycle; inst_o and instAddr_o are updated from the latched values.
  - ready_o=1 (unless flush_i), so a new request may be accepted in the RESP cycle. Back-to-back throughput is one response per LATENCY cycles.
  - Next state: if a request was accepted, WAIT (or RESP when LATENCY==1); otherwise IDLE.
- Timing: a request accepted at edge T produces dataOk_o high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- inst_o, instAddr_o and err_o hold their values between pulses.
- Misaligned address: the response is still produced with the normal latency, inst_o=32'h0, err_o=1. Aligned responses drive err_o=0.
- Address range: address bits above ADDR_W+1 are ignored, so the address wraps modulo the memory size.
- Flush:
  - flush_i=1 in any state means next state=IDLE and ready_o=0 that cycle, so no request is accepted.
  - No dataOk_o for the flushed request. dataOk_o is forced to 0 in a RESP cycle that coincides with flush_i, and inst_o is not updated.
- Write port:
  - The write commits at the clk edge.
  - A same-cycle read of the same word returns the old data (read-before-write).
  - Writes are allowed in every state.
- rst mid-operation: the pending request is discarded, outputs return to reset values the next cycle, and no dataOk_o is produced.
- request_i while ready_o=0 is ignored; the requester must hold or re-issue it.

Optional Feature:
- Macro FETCH_STALL_INJECT_EN.
- When defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst) advances every cycle.
  - On each acceptance, LFSR[1:0] extra wait cycles (0..3) are added to LATENCY.
  - Add output stall_cnt_o[1:0] reporting the extra cycles applied to the current request.
- When undefined: latency is exactly LATENCY, there is no LFSR, and stall_cnt_o is absent.

Test Plan:
- Load and fetch: write mem[4]=32'hDEADBEEF; request instAddr=32'h10, LATENCY=2 -> dataOk_o=1 exactly 2 cycles after acceptance, inst_o=32'hDEADBEEF, instAddr_o=32'h10, err_o=0.
- Back-to-back: requests to 0x0 then 0x4, the second issued in the RESP cycle, with mem[0]=1 and mem[1]=2 -> pulses 2 cycles apart, values 1 then 2, ready_o low during WAIT.
- Misaligned: request 32'h6 -> dataOk_o after 2 cycles, inst_o=0, err_o=1; a following aligned request returns err_o=0.
- Flush: accept a request to 0x8, pulse flush_i in the WAIT cycle -> no dataOk_o, inst_o unchanged, ready_o=1 the following cycle.
- Wrap and reset: ADDR_W=10, request 32'h1000 -> returns mem[0]. Assert rst during WAIT -> no pulse, inst_o=32'h13.
- LATENCY=1: a request every cycle at addresses 0,4,8 -> dataOk_o high three consecutive cycles with the matching data.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder
// Purpose : memory-side responder for the instruction-fetch handshake. Accepts
//           a byte-addressed fetch request, reads a 32-bit word from an
//           internal instruction store and returns it with a one-cycle
//           dataOk_o pulse LATENCY cycles after acceptance.
// Ports   : clk/rst (sync, active-high)
//           request_i, instAddr_i, flush_i -> ready_o       (fetch request side)
//           dataOk_o, inst_o, instAddr_o, err_o             (response side)
//           wr_en_i, wr_addr_i, wr_data_i                   (program-load write port)
//           stall_cnt_o                                     (only with FETCH_STALL_INJECT_EN)
// Option  : define FETCH_STALL_INJECT_EN to add 0..3 pseudo-random extra wait
//           cycles per request (16-bit LFSR) and expose stall_cnt_o.
module inst_fetch_responder #(
  parameter int          ADDR_W     = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_i,
  input  logic [31:0]       instAddr_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              dataOk_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       instAddr_o,
  output logic              err_o,
`ifdef FETCH_STALL_INJECT_EN
  output logic [1:0]        stall_cnt_o,
`endif
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i
);

  // Wide enough for LATENCY-1 (max 14) plus up to 3 injected stall cycles.
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q;   // address of the request in flight
  logic [31:0]        data_q;   // word read at acceptance (0 when misaligned)
  logic               mis_q;    // request in flight is misaligned
  logic [31:0]        inst_q;   // held response values between pulses
  logic [31:0]        iaddr_q;
  logic               err_q;

  logic [31:0]        mem [2**ADDR_W];

  logic               accept;
  logic               resp_fire;
  logic               req_mis;
  logic [ADDR_W-1:0]  rd_idx;
  logic [CNT_W-1:0]   start_cnt;

`ifdef FETCH_STALL_INJECT_EN
  logic [15:0]        lfsr_q;
  logic [1:0]         stall_q;
  logic               lfsr_fb;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign start_cnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
  assign stall_cnt_o = stall_q;
`else
  assign start_cnt = CNT_W'(LATENCY - 1);
`endif

  // Ready is combinational so that a flush blocks acceptance in the same cycle.
  assign ready_o   = !rst && !flush_i && ((state_q == S_IDLE) || (state_q == S_RESP));
  assign accept    = request_i && ready_o;
  // A flush (or reset) landing on the RESP cycle swallows the response.
  assign resp_fire = !rst && !flush_i && (state_q == S_RESP);

  assign req_mis   = |instAddr_i[1:0];
  // Upper address bits are dropped: fetches wrap modulo the memory size.
  assign rd_idx    = instAddr_i[ADDR_W+1:2];

  // Outputs show the in-flight values during the pulse and hold afterwards.
  assign dataOk_o   = resp_fire;
  assign inst_o     = resp_fire ? data_q : inst_q;
  assign instAddr_o = resp_fire ? addr_q : iaddr_q;
  assign err_o      = resp_fire ? mis_q  : err_q;

  // Instruction store: not reset. The read in the FSM block samples the old
  // word when a write to the same address commits on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
      inst_q  <= RESET_INST;
      iaddr_q <= '0;
      err_q   <= 1'b0;
`ifdef FETCH_STALL_INJECT_EN
      lfsr_q  <= 16'hACE1;
      stall_q <= 2'd0;
`endif
    end else begin
`ifdef FETCH_STALL_INJECT_EN
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
`endif
      if (resp_fire) begin
        inst_q  <= data_q;
        iaddr_q <= addr_q;
        err_q   <= mis_q;
      end

      if (accept) begin
        addr_q  <= instAddr_i;
        data_q  <= req_mis ? 32'h0 : mem[rd_idx];
        mis_q   <= req_mis;
        cnt_q   <= start_cnt;
        state_q <= (start_cnt == '0) ? S_RESP : S_WAIT;
`ifdef FETCH_STALL_INJECT_EN
        stall_q <= lfsr_q[1:0];
`endif
      end else if (flush_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
              state_q <= S_RESP;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_RESP:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder
// Purpose : self-checking bench for inst_fetch_responder. A LATENCY=2 instance
//           runs a vector table plus hand sequences; a LATENCY=1 instance
//           (sharing all inputs) covers single-cycle back-to-back fetches.
// Ports   : none (top-level bench).
module tb_inst_fetch_responder;

  logic        clk;
  logic        rst;
  logic        request_i;
  logic [31:0] instAddr_i;
  logic        flush_i;
  logic        wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [31:0] wr_data_i;

  logic        ready0, ok0, err0;
  logic [31:0] inst0, iaddr0;
  logic        ready1, ok1, err1;
  logic [31:0] inst1, iaddr1;
`ifdef FETCH_STALL_INJECT_EN
  logic [1:0]  stall0, stall1;
`endif

  int n_chk;
  int n_fail;

  inst_fetch_responder #(.ADDR_W(10), .LATENCY(2), .RESET_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .request_i(request_i), .instAddr_i(instAddr_i),
    .flush_i(flush_i), .ready_o(ready0), .dataOk_o(ok0), .inst_o(inst0),
    .instAddr_o(iaddr0), .err_o(err0),
`ifdef FETCH_STALL_INJECT_EN
    .stall_cnt_o(stall0),
`endif
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
  );

  inst_fetch_responder #(.ADDR_W(10), .LATENCY(1), .RESET_INST(32'h0000_0013)) dut1 (
    .clk(clk), .rst(rst), .request_i(request_i), .instAddr_i(instAddr_i),
    .flush_i(flush_i), .ready_o(ready1), .dataOk_o(ok1), .inst_o(inst1),
    .instAddr_o(iaddr1), .err_o(err1),
`ifdef FETCH_STALL_INJECT_EN
    .stall_cnt_o(stall1),
`endif
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    @(negedge clk);
    wr_en_i   = 1'b0;
  endtask

  // Issue one fetch on the LATENCY=2 instance from an idle negedge and check
  // latency, returned values and that they hold after the pulse.
  task automatic do_fetch(input string tag, input logic [31:0] a,
                          input logic [31:0] ei, input logic ee);
    int lat;
    request_i  = 1'b1;
    instAddr_i = a;
    #1;
    chk({tag, "_ready"}, 32'(ready0), 32'd1);
    @(negedge clk);
    request_i = 1'b0;
    #1;
    lat = 1;
    while (!ok0 && lat < 8) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_inst"}, inst0, ei);
    chk({tag, "_iaddr"}, iaddr0, a);
    chk({tag, "_err"}, 32'(err0), 32'(ee));
    @(negedge clk);
    #1;
    chk({tag, "_pulse_end"}, 32'(ok0), 32'd0);
    chk({tag, "_hold"}, inst0, ei);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    request_i  = 1'b0;
    instAddr_i = '0;
    flush_i    = 1'b0;
    wr_en_i    = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[2] = '{32'h0000_0004, 32'h0000_0002, 1'b0};
    vecs[3] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0014, 32'h0000_0055, 1'b0};
    vecs[5] = '{32'h0000_1000, 32'h0000_0001, 1'b0};
    vecs[6] = '{32'hFFFF_F008, 32'h3333_3333, 1'b0};
    vecs[7] = '{32'h0000_0003, 32'h0000_0000, 1'b1};

    // Reset state, sampled while rst is still asserted.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_dataok", 32'(ok0), 32'd0);
    chk("rst_inst", inst0, 32'h0000_0013);
    chk("rst_iaddr", iaddr0, 32'h0);
    chk("rst_err", 32'(err0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_ready", 32'(ready0), 32'd1);

    wr(10'd0, 32'h0000_0001);
    wr(10'd1, 32'h0000_0002);
    wr(10'd2, 32'h3333_3333);
    wr(10'd4, 32'hDEAD_BEEF);
    wr(10'd5, 32'h0000_0055);

    // Table: single fetches, misaligned, wrap.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_inst, vecs[i].exp_err);
    end

    // Back-to-back: second request held through WAIT, accepted in RESP.
    request_i = 1'b1; instAddr_i = 32'h0; #1;
    chk("b2b_ready0", 32'(ready0), 32'd1);
    @(negedge clk); instAddr_i = 32'h4; #1;
    chk("b2b_wait_ready", 32'(ready0), 32'd0);
    chk("b2b_wait_ok", 32'(ok0), 32'd0);
    @(negedge clk); #1;
    chk("b2b_resp1_ok", 32'(ok0), 32'd1);
    chk("b2b_resp1_inst", inst0, 32'h1);
    chk("b2b_resp1_ready", 32'(ready0), 32'd1);
    @(negedge clk); request_i = 1'b0; #1;
    chk("b2b_wait2_ok", 32'(ok0), 32'd0);
    chk("b2b_wait2_ready", 32'(ready0), 32'd0);
    @(negedge clk); #1;
    chk("b2b_resp2_ok", 32'(ok0), 32'd1);
    chk("b2b_resp2_inst", inst0, 32'h2);
    chk("b2b_resp2_iaddr", iaddr0, 32'h4);
    @(negedge clk); #1;
    chk("b2b_end_ok", 32'(ok0), 32'd0);

    // Flush during WAIT.
    request_i = 1'b1; instAddr_i = 32'h8;
    @(negedge clk); request_i = 1'b0; flush_i = 1'b1; #1;
    chk("flw_ready", 32'(ready0), 32'd0);
    @(negedge clk); flush_i = 1'b0; #1;
    chk("flw_ok", 32'(ok0), 32'd0);
    chk("flw_inst", inst0, 32'h2);
    chk("flw_ready_after", 32'(ready0), 32'd1);
    @(negedge clk); #1;
    chk("flw_no_late_ok", 32'(ok0), 32'd0);

    // Flush landing on the RESP cycle suppresses the pulse.
    request_i = 1'b1; instAddr_i = 32'h10;
    @(negedge clk); request_i = 1'b0;
    @(negedge clk); flush_i = 1'b1; #1;
    chk("flr_ok", 32'(ok0), 32'd0);
    chk("flr_inst", inst0, 32'h2);
    @(negedge clk); flush_i = 1'b0; #1;
    chk("flr_after_ok", 32'(ok0), 32'd0);
    chk("flr_after_inst", inst0, 32'h2);

    // Read-before-write on the accepting edge, then the new word.
    request_i = 1'b1; instAddr_i = 32'h0;
    wr_en_i = 1'b1; wr_addr_i = 10'd0; wr_data_i = 32'hAAAA_AAAA;
    @(negedge clk); request_i = 1'b0; wr_en_i = 1'b0;
    @(negedge clk); #1;
    chk("rbw_ok", 32'(ok0), 32'd1);
    chk("rbw_old", inst0, 32'h1);
    @(negedge clk);
    do_fetch("rbw_new", 32'h0, 32'hAAAA_AAAA, 1'b0);
    wr(10'd0, 32'h0000_0001);

    // Reset during WAIT.
    @(negedge clk);
    request_i = 1'b1; instAddr_i = 32'h10;
    @(negedge clk); request_i = 1'b0; rst = 1'b1; #1;
    chk("rstw_ready", 32'(ready0), 32'd0);
    chk("rstw_ok", 32'(ok0), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstw_ok2", 32'(ok0), 32'd0);
    chk("rstw_inst", inst0, 32'h0000_0013);
    chk("rstw_iaddr", iaddr0, 32'h0);
    @(negedge clk); #1;
    chk("rstw_ok3", 32'(ok0), 32'd0);

    // LATENCY=1 instance: a request every cycle.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    request_i = 1'b1; instAddr_i = 32'h0; #1;
    chk("l1_ready", 32'(ready1), 32'd1);
    @(negedge clk); instAddr_i = 32'h4; #1;
    chk("l1_ok_a", 32'(ok1), 32'd1);
    chk("l1_inst_a", inst1, 32'h1);
    chk("l1_ready_a", 32'(ready1), 32'd1);
    @(negedge clk); instAddr_i = 32'h8; #1;
    chk("l1_ok_b", 32'(ok1), 32'd1);
    chk("l1_inst_b", inst1, 32'h2);
    @(negedge clk); request_i = 1'b0; #1;
    chk("l1_ok_c", 32'(ok1), 32'd1);
    chk("l1_inst_c", inst1, 32'h3333_3333);
    chk("l1_iaddr_c", iaddr1, 32'h8);
    @(negedge clk); #1;
    chk("l1_end_ok", 32'(ok1), 32'd0);
    chk("l1_hold", inst1, 32'h3333_3333);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
